// File: rtl/gate_sweep_pkg.sv
// Shared types, vector table and the golden gate mapping for the gate sweep checker.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 4;

    // {a,b} driven for vector k
    localparam logic [1:0] VEC_TABLE [NUM_VECTORS] = '{2'b00, 2'b01, 2'b10, 2'b11};

    // Result packed as {y5,y4,y3,y2,y1} = {NOR, NAND, XOR, OR, AND}
    function automatic logic [4:0] gate_expect(input logic a, input logic b);
        return {~(a | b), ~(a & b), a ^ b, a | b, a & b};
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the gates stage under test.
module gate_ref_model
    import gate_sweep_pkg::*;
(
    input  logic       a,
    input  logic       b,
    output logic [4:0] y_exp
);

    assign y_exp = gate_expect(a, b);

endmodule

// File: rtl/gate_sweep_checker.sv
// Steps a gates stage through all four {a,b} vectors, holding each for HOLD_CYCLES,
// and records which vectors produced a result differing from the golden model.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start; a/b parked at 0, results held
// ST_RUN  | driving vector vec_idx, hold_cnt counts down to sample
// ST_DONE | one-cycle completion pulse; a/b back to 0
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [4:0] y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] err_vec
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [1:0] LAST_VEC  = 2'(NUM_VECTORS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold_cnt;
    logic [1:0] vec_idx;
    logic [4:0] y_exp;
    logic       last_hold;
    logic       last_vec;
    logic       mismatch;
    logic [2:0] err_cnt_nxt;

    gate_ref_model u_ref (
        .a     (a),
        .b     (b),
        .y_exp (y_exp)
    );

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign {a, b} = busy ? VEC_TABLE[vec_idx] : 2'b00;

    // Only the final hold cycle of each vector is judged; earlier cycles may still be settling.
    assign last_hold   = busy && (hold_cnt == 8'd0);
    assign last_vec    = (vec_idx == LAST_VEC);
    assign mismatch    = last_hold && (y_in != y_exp);
    assign err_cnt_nxt = (mismatch && (err_count < 3'd4)) ? err_count + 3'd1 : err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last_hold && last_vec) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= 8'd0;
            vec_idx   <= 2'd0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            err_vec   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        hold_cnt  <= HOLD_LOAD;
                        vec_idx   <= 2'd0;
                        pass      <= 1'b0;
                        err_count <= 3'd0;
                        err_vec   <= 4'd0;
                    end
                end
                ST_RUN: begin
                    if (mismatch) begin
                        err_vec[vec_idx] <= 1'b1;
                        err_count        <= err_cnt_nxt;
                    end
                    if (hold_cnt == 8'd0) begin
                        hold_cnt <= HOLD_LOAD;
                        vec_idx  <= vec_idx + 2'd1;
                        if (last_vec) begin
                            pass <= (err_cnt_nxt == 3'd0);
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Randomized scoreboard bench for gate_sweep_checker with an arithmetic timing model.
module tb_gate_sweep_checker;

    localparam int HOLD = 4;
    localparam int SWEEP = 4 * HOLD;

    // Truth table of the gates stage indexed by {a,b}, packed {y5..y1}
    localparam logic [4:0] GATES_TBL [4] = '{5'b11000, 5'b01110, 5'b01110, 5'b00011};

    typedef struct {
        int         done_cyc;
        logic [3:0] ev;
        logic [2:0] cnt;
        logic       pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       a, b, busy, done, pass;
    logic [4:0] y_in;
    logic [2:0] err_count;
    logic [3:0] err_vec;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   active = 1'b0;
    int   act_t = 0;
    bit   stuck_y3 = 1'b0;
    int   mask_mode = 0;
    logic [4:0] last_mask [4];
    logic [4:0] glitch = 5'd1;
    exp_t sb[$];
    exp_t held;

    gate_sweep_checker #(.HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .err_vec   (err_vec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) glitch <= 5'($urandom_range(1, 31));

    // Gates stage: correct result, corrupted by the planned mask of the current hold cycle
    always_comb begin
        int off;
        logic [4:0] mask;
        mask = 5'd0;
        off = cyc - act_t - 1;
        if (active && off >= 0 && off < SWEEP) begin
            if (off % HOLD == HOLD - 1) mask = last_mask[off / HOLD];
            else mask = glitch;
        end
        y_in = GATES_TBL[{a, b}] ^ mask;
        if (stuck_y3) y_in[2] = 1'b0;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic model_start();
        exp_t e;
        logic [4:0] obs;
        if (rst || (active && cyc < act_t + SWEEP + 2)) return;
        active = 1'b1;
        act_t = cyc;
        e.ev = 4'd0;
        e.cnt = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (mask_mode == 0 || $urandom_range(0, 1) == 0) last_mask[k] = 5'd0;
            else last_mask[k] = 5'($urandom_range(1, 31));
            obs = GATES_TBL[k] ^ last_mask[k];
            if (stuck_y3) obs[2] = 1'b0;
            if (obs != GATES_TBL[k]) begin
                e.ev[k] = 1'b1;
                e.cnt = e.cnt + 3'd1;
            end
        end
        e.pass = (e.cnt == 3'd0);
        e.done_cyc = act_t + SWEEP + 1;
        sb.push_back(e);
    endtask

    task automatic step(input bit s);
        @(negedge clk);
        start = s;
        if (s) model_start();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        active = 1'b0;
        sb.delete();
        held = '{0, 4'd0, 3'd0, 1'b0};
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0);
    endtask

    // Monitor: per-cycle timing checks plus scoreboard pop on every done pulse
    initial begin
        exp_t e;
        int off;
        bit in_run, is_done;
        forever begin
            @(posedge clk);
            #1;
            off = cyc - act_t - 1;
            in_run = active && off >= 0 && off < SWEEP;
            is_done = active && off == SWEEP;
            check("busy", int'(busy), int'(in_run));
            check("done", int'(done), int'(is_done));
            check("ab", int'({a, b}), in_run ? off / HOLD : 0);
            if (in_run && off == 0) begin
                check("clr_vec", int'(err_vec), 0);
                check("clr_cnt", int'(err_count), 0);
                check("clr_pass", int'(pass), 0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done cyc=%0d actual=1 required=0", cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_cyc", cyc, e.done_cyc);
                    check("err_vec", int'(err_vec), int'(e.ev));
                    check("err_count", int'(err_count), int'(e.cnt));
                    check("pass", int'(pass), int'(e.pass));
                    held = e;
                end
            end else if (!in_run) begin
                check("hold_vec", int'(err_vec), int'(held.ev));
                check("hold_cnt", int'(err_count), int'(held.cnt));
                check("hold_pass", int'(pass), int'(held.pass));
            end
        end
    end

    initial begin
        held = '{0, 4'd0, 3'd0, 1'b0};
        do_reset(3);
        idle(3);

        // clean sweep
        mask_mode = 0;
        step(1'b1); idle(20);

        // y3 stuck at 0: vectors 1 and 2 fail
        stuck_y3 = 1'b1;
        step(1'b1); idle(20);
        stuck_y3 = 1'b0;

        // re-pulsed start during the run is ignored
        step(1'b1); idle(4); step(1'b1); idle(4); step(1'b1); idle(12);

        // reset in vector 2, then a clean full sweep
        mask_mode = 1;
        step(1'b1); idle(9);
        do_reset(2);
        idle(2);
        mask_mode = 0;
        step(1'b1); idle(20);

        // start in the done cycle is ignored, one cycle later accepted
        mask_mode = 1;
        step(1'b1); idle(16); step(1'b1); step(1'b1); idle(20);

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1);
            end else begin
                step($urandom_range(0, 7) == 0);
            end
        end
        idle(25);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
